instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//   Multicycle control FSM for the 16-bit core. Sequences fetch, decode, execute, memory and write-back around main_decoder.
//   Gates the decoder's static control flags into single-cycle enables. Owns the req/ready handshake to the shared instruction/data memory.
// PARAMETERS
//   HALT_OP      5'b11111  opcode (IR[15:11]) that enters HALT
//   MEM_TIMEOUT  16        max consecutive non-ready cycles per memory access before ERR; must be >= 2
// PORTS
//   clk            in   1  rising-edge clock
//   rst_n          in   1  asynchronous reset, active-low
//   start          in   1  pulse; leaves IDLE and begins fetch at current PC
//   opcode         in   5  IR[15:11] from the instruction register
//   dec_mem_write  in   1  MemWrite from main_decoder
//   dec_result_src in   1  ResultSrc from main_decoder (1 = load)
//   dec_reg_write  in   1  RegWrite from main_decoder
//   dec_branch     in   1  Branch from main_decoder
//   dec_jump       in   1  Jump from main_decoder
//   zero           in   1  ALU zero flag
//   mem_ready      in   1  memory completes the access this cycle
//   mem_req        out  1  memory access request
//   mem_we         out  1  write strobe, qualified by mem_req
//   mem_sel        out  1  address mux select: 0 = PC, 1 = ALU result
//   ir_write       out  1  load IR from memory read data
//   pc_write       out  1  update PC
//   pc_src         out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target
//   reg_write_en   out  1  register file write enable
//   busy           out  1  state is FETCH..WB
//   halted         out  1  state is HALT
//   error          out  1  state is ERR
//   state          out  3  current state, for debug
// BEHAVIOUR
//   - Only the state register and the timeout counter are registered. All enables are combinational from state and inputs; each is a 1-cycle pulse.
//   - State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
//   - Reset (async, rst_n=0): state=IDLE, counter=0. Every output is 0 immediately, including mid-access; no enable is asserted.
//   - IDLE: start=1 -> FETCH.
//   - FETCH: mem_req=1, mem_sel=0, mem_we=0, held until mem_ready.
//       In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=00; next state DECODE.
//   - DECODE: 1 cycle. opcode==HALT_OP -> HALT; otherwise -> EXEC.
//   - EXEC: 1 cycle. Priority is jump > branch > mem > reg:
//       dec_jump   -> pc_write=1, pc_src=10; -> FETCH.
//       dec_branch -> pc_write=zero, pc_src=01; -> FETCH.
//       dec_mem_write | dec_result_src -> MEM.
//       dec_reg_write -> WB.
//       none set -> FETCH (NOP).
//   - MEM: mem_req=1, mem_sel=1, mem_we=dec_mem_write, held until mem_ready.
//       On mem_ready: store -> FETCH; load -> WB.
//   - WB: reg_write_en=1 for 1 cycle; -> FETCH.
//   - Timeout counter:
//       Cleared on entry to FETCH and MEM; increments each cycle mem_req=1 and mem_ready=0.
//       After MEM_TIMEOUT consecutive non-ready cycles, next state is ERR; mem_req is 0 from that edge.
//       mem_ready in the final wait cycle wins over timeout.
//   - mem_ready while mem_req=0 is ignored.
//   - HALT and ERR are sticky until rst_n; start is ignored in both.
//   - Latency with zero-wait memory (mem_ready in the request cycle):
//       ALU 4 cycles, load 5, store 4, branch/jump/NOP 3.
//       Each memory wait cycle adds 1.
// STRUCTURE
//   - Shared include core_defs.vh holds: state encodings, pc_src codes, HALT_OP default. main_decoder uses the same file.
//   - One sub-module, mem_timeout_ctr: inputs clr, en; output expired; parameter MEM_TIMEOUT.
// TESTING
//   1. Reset, start, ALU op (dec_reg_write=1), mem_ready tied 1
//      -> state 1,2,3,5,1; pc_write once in FETCH; reg_write_en high exactly at cycle 4.
//   2. Load, mem_ready withheld 3 cycles in MEM
//      -> mem_req=1, mem_sel=1, mem_we=0 for 4 cycles; then WB pulse; back to FETCH.
//   3. Store (dec_mem_write=1)
//      -> mem_we=1 only in MEM; no reg_write_en; next state FETCH.
//   4. Branch with zero=1, then zero=0
//      -> pc_write with pc_src=01 only when zero=1.
//      dec_jump and dec_branch both set -> pc_src=10.
//   5. mem_ready held 0 in FETCH, MEM_TIMEOUT=16
//      -> ERR after 16 wait cycles; error=1; mem_req=0; start ignored until rst_n.
//   6. opcode=5'b11111 -> HALT, halted=1, busy=0.
//      Separately, rst_n pulled low mid-MEM -> all outputs 0 asynchronously; state=IDLE.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: state encodings, PC source codes
// and the default HALT opcode used by both the sequencer and the main decoder.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [4:0] HALT_OP_DEFAULT = 5'b11111;

    function automatic logic is_busy(input state_e s);
        return (s >= ST_FETCH) && (s <= ST_WB);
    endfunction

endpackage

// File: rtl/instr_sequencer_mem_timeout_ctr.sv
// Counts consecutive non-ready cycles of one memory access; expired flags the
// final allowed wait cycle so the sequencer can divert to ERR on that edge.
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This wait cycle is the MEM_TIMEOUT-th one in a row.
    assign expired = en && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle control FSM: fetch/decode/execute/memory/write-back sequencing with
// single-cycle enables and the req/ready handshake to the shared memory.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [4:0] HALT_OP     = HALT_OP_DEFAULT,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] opcode,
    input  logic       dec_mem_write,
    input  logic       dec_result_src,
    input  logic       dec_reg_write,
    input  logic       dec_branch,
    input  logic       dec_jump,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write_en,
    output logic       busy,
    output logic       halted,
    output logic       error,
    output logic [2:0] state
);

    state_e state_q;
    state_e state_d;
    logic   mem_wait;
    logic   tmo_clr;
    logic   tmo_expired;

    // Kept outside the FSM block so the timeout path has no block-level loop.
    assign mem_req  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign mem_wait = mem_req && !mem_ready;
    assign tmo_clr  = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

    mem_timeout_ctr #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (mem_wait),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        mem_we       = 1'b0;
        mem_sel      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_SEQ;
        reg_write_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                state_d = (opcode == HALT_OP) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    state_d  = ST_FETCH;
                end else if (dec_branch) begin
                    pc_write = zero;
                    pc_src   = PC_SRC_BRANCH;
                    state_d  = ST_FETCH;
                end else if (dec_mem_write || dec_result_src) begin
                    state_d = ST_MEM;
                end else if (dec_reg_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_sel = 1'b1;
                mem_we  = dec_mem_write;
                if (mem_ready) begin
                    state_d = dec_mem_write ? ST_FETCH : ST_WB;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy   = is_busy(state_q);
    assign halted = (state_q == ST_HALT);
    assign error  = (state_q == ST_ERR);
    assign state  = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: walks ALU, load, store, branch/jump, timeout,
// HALT and async reset with hand-computed output vectors per cycle.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] opcode;
    logic       dec_mem_write;
    logic       dec_result_src;
    logic       dec_reg_write;
    logic       dec_branch;
    logic       dec_jump;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write_en;
    logic       busy;
    logic       halted;
    logic       error;
    logic [2:0] state;

    int total_cnt = 0;
    int bad_cnt   = 0;

    instr_sequencer #(
        .HALT_OP     (5'b11111),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .opcode         (opcode),
        .dec_mem_write  (dec_mem_write),
        .dec_result_src (dec_result_src),
        .dec_reg_write  (dec_reg_write),
        .dec_branch     (dec_branch),
        .dec_jump       (dec_jump),
        .zero           (zero),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_sel        (mem_sel),
        .ir_write       (ir_write),
        .pc_write       (pc_write),
        .pc_src         (pc_src),
        .reg_write_en   (reg_write_en),
        .busy           (busy),
        .halted         (halted),
        .error          (error),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed vector: {req, we, sel, ir_write, pc_write, pc_src[1:0], reg_write_en, busy, halted, error, state[2:0]}
    function automatic logic [13:0] pk(input logic req, input logic we, input logic sel,
                                       input logic irw, input logic pcw, input logic [1:0] src,
                                       input logic rwe, input logic [2:0] st);
        logic b;
        logic h;
        logic e;
        b = (st >= 3'd1) && (st <= 3'd5);
        h = (st == 3'd6);
        e = (st == 3'd7);
        return {req, we, sel, irw, pcw, src, rwe, b, h, e, st};
    endfunction

    task automatic check_val(input string tag, input logic [13:0] got, input logic [13:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic expect_out(input string tag, input logic [13:0] exp);
        #1;
        check_val(tag, {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src,
                        reg_write_en, busy, halted, error, state}, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 5'd0; zero = 1'b0; mem_ready = 1'b0;
        dec_mem_write = 1'b0; dec_result_src = 1'b0; dec_reg_write = 1'b0;
        dec_branch = 1'b0; dec_jump = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_out("reset_idle", pk(0,0,0,0,0,2'b00,0,3'd0));

        // 1: ALU op, zero-wait memory
        start = 1'b1; mem_ready = 1'b1; dec_reg_write = 1'b1;
        expect_out("alu_idle_start", pk(0,0,0,0,0,2'b00,0,3'd0));
        tick; start = 1'b0;
        expect_out("alu_fetch", pk(1,0,0,1,1,2'b00,0,3'd1));
        tick; expect_out("alu_decode", pk(0,0,0,0,0,2'b00,0,3'd2));
        tick; expect_out("alu_exec", pk(0,0,0,0,0,2'b00,0,3'd3));
        tick; expect_out("alu_wb", pk(0,0,0,0,0,2'b00,1,3'd5));
        tick; dec_result_src = 1'b1;
        expect_out("alu_back_fetch", pk(1,0,0,1,1,2'b00,0,3'd1));

        // 2: load with 3 wait cycles in MEM
        tick; tick; mem_ready = 1'b0;
        expect_out("ld_exec", pk(0,0,0,0,0,2'b00,0,3'd3));
        for (int i = 0; i < 3; i++) begin
            tick; expect_out($sformatf("ld_mem_wait%0d", i), pk(1,0,1,0,0,2'b00,0,3'd4));
        end
        tick; mem_ready = 1'b1;
        expect_out("ld_mem_ready", pk(1,0,1,0,0,2'b00,0,3'd4));
        tick; expect_out("ld_wb", pk(0,0,0,0,0,2'b00,1,3'd5));
        tick; dec_result_src = 1'b0; dec_reg_write = 1'b0; dec_mem_write = 1'b1;
        expect_out("ld_back_fetch", pk(1,0,0,1,1,2'b00,0,3'd1));

        // 3: store
        tick; tick; expect_out("st_exec", pk(0,0,0,0,0,2'b00,0,3'd3));
        tick; expect_out("st_mem", pk(1,1,1,0,0,2'b00,0,3'd4));
        tick; dec_mem_write = 1'b0; dec_branch = 1'b1; zero = 1'b1;
        expect_out("st_back_fetch", pk(1,0,0,1,1,2'b00,0,3'd1));

        // 4: branch taken, not taken, then jump+branch
        tick; tick; expect_out("br_taken", pk(0,0,0,0,1,2'b01,0,3'd3));
        tick; tick; zero = 1'b0; tick;
        expect_out("br_not_taken", pk(0,0,0,0,0,2'b01,0,3'd3));
        tick; tick; dec_jump = 1'b1; tick;
        expect_out("jump_over_branch", pk(0,0,0,0,1,2'b10,0,3'd3));
        tick; dec_jump = 1'b0; dec_branch = 1'b0; mem_ready = 1'b0;

        // 5: FETCH timeout after 16 wait cycles
        expect_out("tmo_wait1", pk(1,0,0,0,0,2'b00,0,3'd1));
        repeat (14) tick;
        expect_out("tmo_wait15", pk(1,0,0,0,0,2'b00,0,3'd1));
        tick; expect_out("tmo_wait16", pk(1,0,0,0,0,2'b00,0,3'd1));
        tick; expect_out("tmo_err", pk(0,0,0,0,0,2'b00,0,3'd7));
        start = 1'b1; mem_ready = 1'b1;
        tick; tick; expect_out("err_sticky", pk(0,0,0,0,0,2'b00,0,3'd7));
        start = 1'b0; rst_n = 1'b0;
        expect_out("err_reset", pk(0,0,0,0,0,2'b00,0,3'd0));
        #2 rst_n = 1'b1;

        // 6: HALT opcode
        tick; start = 1'b1; opcode = 5'b11111;
        tick; start = 1'b0;
        tick; expect_out("halt_decode", pk(0,0,0,0,0,2'b00,0,3'd2));
        tick; expect_out("halt_state", pk(0,0,0,0,0,2'b00,0,3'd6));
        start = 1'b1;
        tick; tick; expect_out("halt_sticky", pk(0,0,0,0,0,2'b00,0,3'd6));
        start = 1'b0; rst_n = 1'b0; #2 rst_n = 1'b1;

        // async reset mid-MEM
        tick; start = 1'b1; opcode = 5'd0; dec_result_src = 1'b1; dec_reg_write = 1'b1;
        tick; start = 1'b0;
        tick; tick; mem_ready = 1'b0;
        tick; expect_out("rst_pre_mem", pk(1,0,1,0,0,2'b00,0,3'd4));
        #2 rst_n = 1'b0;
        expect_out("rst_mid_mem", pk(0,0,0,0,0,2'b00,0,3'd0));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
